fir_frame_collector: RTL and testbench

Receive-side companion to the 4-tap FIR datapath. It consumes the FIR's valid-flagged signed 16-bit output stream and packs every four consecutive valid samples into one frame. The frame is 64 bits, in `[0:3][15:0]` element order, and is emitted together with its exact 18-bit signed sum. Output uses a ready/valid handshake behind a 2-entry frame FIFO. The FIR cannot stall, so the input has no backpressure; frames that cannot be stored are dropped and flagged.

---
 rtl/fir_frame_collector_if.sv | 37 +++
 rtl/fir_frame_collector.sv | 138 +++++++++++++
 tb/tb_fir_frame_collector.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_collector_if
//  Description : Bundle of the sample-input, flush, frame-output and status
//                signals of fir_frame_collector.
//                  in_valid / in_data  : FIR output tuple (no backpressure)
//                  flush               : discard the partial frame
//                  out_valid/out_ready : ready/valid handshake of the head frame
//                  out_frame / out_sum : head frame (element 0 in [63:48]) and
//                                        its exact signed 18-bit sum
//                  fill / overflow     : partial-frame depth, sticky drop flag
//                slave  : collector side
//                master : producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_frame_collector_if;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_frame;
    logic signed [17:0] out_sum;
    logic [1:0]         fill;
    logic               overflow;

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_frame, out_sum, fill, overflow
    );

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_frame, out_sum, fill, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fir_frame_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fir_frame_collector
//  Description : Packs every four valid FIR samples into a 64-bit frame plus
//                its exact 18-bit signed sum and queues it in a 2-entry FIFO
//                with a ready/valid output. The input cannot be stalled, so a
//                frame completing while the FIFO is full (and not popping) is
//                dropped and the sticky overflow flag is raised.
//  Ports       : clk  - single clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - fir_frame_collector_if.slave (samples, flush,
//                       frame handshake, fill, overflow)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_collector (
    input  wire logic             clk,
    input  wire logic             rst,
    fir_frame_collector_if.slave  bus
);

    // ------------------------------------------------------------------
    // Assembly stage
    // ------------------------------------------------------------------
    logic [1:0]         cnt_q,  cnt_d;
    logic signed [17:0] sum_q,  sum_d;
    // Element 3 never needs storage: it is taken straight from in_data
    // on the completing cycle.
    logic [15:0]        elem0_q, elem1_q, elem2_q;

    logic               accept;
    logic               last;
    logic signed [17:0] sample_ext;
    logic signed [17:0] sum_new;
    logic [63:0]        frame_new;

    // ------------------------------------------------------------------
    // Frame FIFO (2 entries)
    // ------------------------------------------------------------------
    logic [63:0]        frame_mem_q [2];
    logic signed [17:0] sum_mem_q   [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         count_q, count_d;
    logic               overflow_q;

    logic               pop;
    logic               full;
    logic               push_ok;
    logic               drop;

    always_comb begin
        accept     = bus.in_valid && !bus.flush;
        last       = accept && (cnt_q == 2'd3);
        sample_ext = {{2{bus.in_data[15]}}, bus.in_data};
        sum_new    = sum_q + sample_ext;
        frame_new  = {elem0_q, elem1_q, elem2_q, bus.in_data};

        // Flush wins over a sample presented in the same cycle.
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (bus.flush) begin
            cnt_d = 2'd0;
            sum_d = 18'sd0;
        end else if (accept) begin
            cnt_d = cnt_q + 2'd1;   // 3 wraps to 0 naturally
            sum_d = last ? 18'sd0 : sum_new;
        end
    end

    always_comb begin
        pop     = (count_q != 2'd0) && bus.out_ready;
        full    = (count_q == 2'd2);
        // A pop in the same cycle frees the slot for the incoming frame.
        push_ok = last && (!full || pop);
        drop    = last && full && !pop;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= 2'd0;
            sum_q          <= 18'sd0;
            elem0_q        <= 16'd0;
            elem1_q        <= 16'd0;
            elem2_q        <= 16'd0;
            frame_mem_q[0] <= 64'd0;
            frame_mem_q[1] <= 64'd0;
            sum_mem_q[0]   <= 18'sd0;
            sum_mem_q[1]   <= 18'sd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            overflow_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;

            if (accept) begin
                case (cnt_q)
                    2'd0:    elem0_q <= bus.in_data;
                    2'd1:    elem1_q <= bus.in_data;
                    2'd2:    elem2_q <= bus.in_data;
                    default: ;
                endcase
            end

            if (push_ok) begin
                frame_mem_q[wr_ptr_q] <= frame_new;
                sum_mem_q[wr_ptr_q]   <= sum_new;
                wr_ptr_q              <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers; out_valid has no path from
    // out_ready.
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_frame = frame_mem_q[rd_ptr_q];
    assign bus.out_sum   = sum_mem_q[rd_ptr_q];
    assign bus.fill      = cnt_q;
    assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_frame_collector
//  Description : Scoreboard bench for fir_frame_collector. Directed stimulus
//                pushes hand-computed {frame, sum} into a queue; a monitor on
//                the falling edge pops and compares on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_frame_collector_if bus ();

    fir_frame_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [81:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [63:0] f, input logic [17:0] s);
        exp_q.push_back({f, s});
    endtask

    // Monitor: a handshake sampled here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            logic [81:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_frame: got %h sum %h expected none",
                         bus.out_frame, bus.out_sum);
            end else begin
                n_checks--;
                e = exp_q.pop_front();
                chk("frame", bus.out_frame, e[81:18]);
                chk("sum", {46'd0, bus.out_sum}, {46'd0, e[17:0]});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic drain(input string name);
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, {63'd0, exp_q.size() == 0}, 64'd1);
        exp_q.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    localparam logic [63:0] FA = 64'h0001_0002_0003_0004;
    localparam logic [17:0] SA = 18'h0000A;
    localparam logic [63:0] FB = 64'h000A_0014_001E_0028;
    localparam logic [17:0] SB = 18'h00064;
    localparam logic [63:0] FC = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [17:0] SC = 18'h3FFFC;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 16'($urandom);
            bus.flush     = 1'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
        end
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_frame", bus.out_frame, 64'd0);
        chk("rst_out_sum",   {46'd0, bus.out_sum}, 64'd0);
        chk("rst_fill",      {62'd0, bus.fill}, 64'd0);
        chk("rst_overflow",  {63'd0, bus.overflow}, 64'd0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;

        // Reset mid-frame
        send(16'd9); send(16'd9);
        chk("mid_fill_2", {62'd0, bus.fill}, 64'd2);
        do_reset();
        chk("mid_rst_fill", {62'd0, bus.fill}, 64'd0);
        send(16'd9); send(16'd9);
        repeat (3) tick();
        chk("mid_rst_no_frame", {63'd0, bus.out_valid}, 64'd0);
        do_reset();

        // Single frame, latency and release
        expect_frame(64'h0001_FFFE_0003_FFFC, 18'h3FFFE);
        send4(16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC);
        chk("single_valid_up", {63'd0, bus.out_valid}, 64'd1);
        chk("single_sum_direct", {46'd0, bus.out_sum}, {46'd0, 18'h3FFFE});
        tick();
        chk("single_valid_down", {63'd0, bus.out_valid}, 64'd0);
        drain("single_drain");

        // Extreme values
        expect_frame(64'h8000_8000_8000_8000, 18'h20000);
        send4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        expect_frame(64'h7FFF_7FFF_7FFF_7FFF, 18'h1FFFC);
        send4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        drain("extreme_drain");

        // Gapped samples
        expect_frame(64'h0001_FFFE_0003_FFFC, 18'h3FFFE);
        send(16'h0001); chk("gap_fill1", {62'd0, bus.fill}, 64'd1);
        tick();         chk("gap_fill1_hold", {62'd0, bus.fill}, 64'd1);
        send(16'hFFFE); chk("gap_fill2", {62'd0, bus.fill}, 64'd2);
        tick(); tick();
        send(16'h0003); chk("gap_fill3", {62'd0, bus.fill}, 64'd3);
        tick();
        send(16'hFFFC); chk("gap_fill0", {62'd0, bus.fill}, 64'd0);
        drain("gap_drain");

        // Overflow: A, B stored, C dropped
        bus.out_ready = 1'b0;
        expect_frame(FA, SA);
        expect_frame(FB, SB);
        send4(16'd1, 16'd2, 16'd3, 16'd4);
        send4(16'd10, 16'd20, 16'd30, 16'd40);
        chk("ovf_before_c", {63'd0, bus.overflow}, 64'd0);
        send4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        chk("ovf_set", {63'd0, bus.overflow}, 64'd1);
        chk("ovf_head_a", bus.out_frame, FA);
        bus.out_ready = 1'b1;
        tick();
        chk("ovf_b_next_cycle", {63'd0, bus.out_valid}, 64'd1);
        tick();
        chk("ovf_empty_after_b", {63'd0, bus.out_valid}, 64'd0);
        repeat (3) tick();
        chk("ovf_sticky", {63'd0, bus.overflow}, 64'd1);
        drain("ovf_drain");
        do_reset();
        chk("ovf_cleared", {63'd0, bus.overflow}, 64'd0);

        // Pop-and-push while full
        bus.out_ready = 1'b0;
        expect_frame(FA, SA);
        expect_frame(FB, SB);
        expect_frame(FC, SC);
        send4(16'd1, 16'd2, 16'd3, 16'd4);
        send4(16'd10, 16'd20, 16'd30, 16'd40);
        send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
        bus.out_ready = 1'b1;
        send(16'hFFFF);
        chk("pp_no_overflow", {63'd0, bus.overflow}, 64'd0);
        drain("pp_drain");
        chk("pp_overflow_final", {63'd0, bus.overflow}, 64'd0);

        // Flush
        send(16'd3); send(16'd4);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_fill", {62'd0, bus.fill}, 64'd0);
        bus.flush = 1'b1;
        send(16'd7);
        bus.flush = 1'b0;
        chk("flush_discard", {62'd0, bus.fill}, 64'd0);
        expect_frame(64'h0005_0006_0007_0008, 18'd26);
        send4(16'd5, 16'd6, 16'd7, 16'd8);
        drain("flush_drain");

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
